video_timer_cfg: RTL

- Parametrised, runtime-reconfigurable successor to the fixed-timing VGA video timer.
- Generates hsync/vsync/visible, pixel coordinates, line/frame strobes and a frame counter from a timing set loaded over a valid/ready config port.
- New timing is applied only at a frame boundary. Adds a pixel-clock-enable divider and per-axis sync polarity.
- Sits between the clock/reset block and the pixel generators and video output driver.

---
 rtl/video_timer_cfg.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/video_timer_cfg.sv
// Runtime-reconfigurable video timing generator: sync/visible decode, pixel
// coordinates and frame counting, with new timing taking effect at frame wrap.
module video_timer_cfg #(
    parameter int CW            = 12,
    parameter int FRAME_W       = 32,
    parameter int PIX_DIV       = 1,
    parameter int DEF_H_VISIBLE = 640,
    parameter int DEF_H_FRONT   = 16,
    parameter int DEF_H_SYNC    = 96,
    parameter int DEF_H_BACK    = 48,
    parameter int DEF_V_VISIBLE = 480,
    parameter int DEF_V_FRONT   = 10,
    parameter int DEF_V_SYNC    = 2,
    parameter int DEF_V_BACK    = 33,
    parameter bit DEF_HSYNC_POL = 1'b0,
    parameter bit DEF_VSYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CW-1:0]      cfg_h_visible,
    input  logic [CW-1:0]      cfg_h_front,
    input  logic [CW-1:0]      cfg_h_sync,
    input  logic [CW-1:0]      cfg_h_back,
    input  logic [CW-1:0]      cfg_v_visible,
    input  logic [CW-1:0]      cfg_v_front,
    input  logic [CW-1:0]      cfg_v_sync,
    input  logic [CW-1:0]      cfg_v_back,
    input  logic               cfg_hsync_pol,
    input  logic               cfg_vsync_pol,
    output logic               cfg_error,
    output logic               pix_en,
    output logic               hsync,
    output logic               vsync,
    output logic               visible,
    output logic [CW-1:0]      position_x,
    output logic [CW-1:0]      position_y,
    output logic [CW-1:0]      position_x_next,
    output logic [CW-1:0]      position_y_next,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame
);

    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    // Two extra bits so a sum of four CW-bit fields can never wrap.
    localparam int TW = CW + 2;
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

    localparam logic [CW-1:0] DEF_H [4] = '{CW'(DEF_H_VISIBLE), CW'(DEF_H_FRONT),
                                            CW'(DEF_H_SYNC), CW'(DEF_H_BACK)};
    localparam logic [CW-1:0] DEF_V [4] = '{CW'(DEF_V_VISIBLE), CW'(DEF_V_FRONT),
                                            CW'(DEF_V_SYNC), CW'(DEF_V_BACK)};
    localparam logic [CW-1:0] DEF_X0 = CW'(DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC);
    localparam logic [CW-1:0] DEF_Y0 = CW'(DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC);

    logic [CW-1:0] cfg_h [4];
    logic [CW-1:0] cfg_v [4];
    assign cfg_h[0] = cfg_h_visible;
    assign cfg_h[1] = cfg_h_front;
    assign cfg_h[2] = cfg_h_sync;
    assign cfg_h[3] = cfg_h_back;
    assign cfg_v[0] = cfg_v_visible;
    assign cfg_v[1] = cfg_v_front;
    assign cfg_v[2] = cfg_v_sync;
    assign cfg_v[3] = cfg_v_back;

    logic [CW-1:0]      act_h_reg [4];
    logic [CW-1:0]      act_v_reg [4];
    logic [CW-1:0]      pend_h_reg [4];
    logic [CW-1:0]      pend_v_reg [4];
    logic               act_hpol_reg, act_vpol_reg;
    logic               pend_hpol_reg, pend_vpol_reg;
    logic               pending_reg;
    logic               cfg_error_reg;
    logic [DW-1:0]      div_reg;
    logic [CW-1:0]      x_reg, y_reg;
    logic [CW-1:0]      pos_x_reg, pos_y_reg;
    logic [FRAME_W-1:0] frame_reg;

    // Offered-config validation
    logic [7:0]    field_zero;
    logic [TW-1:0] cfg_h_total, cfg_v_total;
    logic          cfg_bad, transfer;

    for (genvar gi = 0; gi < 4; gi++) begin : g_field_chk
        assign field_zero[gi]     = (cfg_h[gi] == '0);
        assign field_zero[gi + 4] = (cfg_v[gi] == '0);
    end

    assign cfg_h_total = TW'(cfg_h[0]) + TW'(cfg_h[1]) + TW'(cfg_h[2]) + TW'(cfg_h[3]);
    assign cfg_v_total = TW'(cfg_v[0]) + TW'(cfg_v[1]) + TW'(cfg_v[2]) + TW'(cfg_v[3]);
    assign cfg_bad = (|field_zero) || (cfg_h_total[TW-1:CW] != '0)
                  || (cfg_v_total[TW-1:CW] != '0);
    assign cfg_ready = rst_n && !pending_reg;
    assign transfer  = cfg_valid && cfg_ready;

    // Active-timing boundaries; accepted totals are < 2^CW so CW bits suffice.
    logic [CW-1:0] h_sync_start, h_sync_end, h_last;
    logic [CW-1:0] v_sync_start, v_sync_end, v_last;
    assign h_sync_start = act_h_reg[0] + act_h_reg[1];
    assign h_sync_end   = h_sync_start + act_h_reg[2];
    assign h_last       = h_sync_end + act_h_reg[3] - 1'b1;
    assign v_sync_start = act_v_reg[0] + act_v_reg[1];
    assign v_sync_end   = v_sync_start + act_v_reg[2];
    assign v_last       = v_sync_end + act_v_reg[3] - 1'b1;

    logic          x_last, y_last, frame_wrap;
    logic [CW-1:0] x_next, y_next;
    assign x_last     = (x_reg == h_last);
    assign y_last     = (y_reg == v_last);
    assign x_next     = x_last ? '0 : x_reg + 1'b1;
    assign y_next     = x_last ? (y_last ? '0 : y_reg + 1'b1) : y_reg;
    assign pix_en     = rst_n && (div_reg == DIV_LAST);
    assign frame_wrap = pix_en && x_last && y_last;

    assign position_x_next = (x_next < act_h_reg[0]) ? x_next : '0;
    assign position_y_next = (y_next < act_v_reg[0]) ? y_next : '0;

    logic hs_active, vs_active;
    assign hs_active   = (x_reg >= h_sync_start) && (x_reg < h_sync_end);
    assign vs_active   = (y_reg >= v_sync_start) && (y_reg < v_sync_end);
    assign hsync       = (rst_n && hs_active) ? act_hpol_reg : ~act_hpol_reg;
    assign vsync       = (rst_n && vs_active) ? act_vpol_reg : ~act_vpol_reg;
    assign visible     = rst_n && (x_reg < act_h_reg[0]) && (y_reg < act_v_reg[0]);
    assign line_start  = pix_en && (x_reg == '0);
    assign frame_start = line_start && (y_reg == '0);
    assign cfg_error   = rst_n && cfg_error_reg;
    assign position_x  = pos_x_reg;
    assign position_y  = pos_y_reg;
    assign frame       = frame_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                act_h_reg[i]  <= DEF_H[i];
                act_v_reg[i]  <= DEF_V[i];
                pend_h_reg[i] <= '0;
                pend_v_reg[i] <= '0;
            end
            act_hpol_reg  <= DEF_HSYNC_POL;
            act_vpol_reg  <= DEF_VSYNC_POL;
            pend_hpol_reg <= 1'b0;
            pend_vpol_reg <= 1'b0;
            pending_reg   <= 1'b0;
            cfg_error_reg <= 1'b0;
            div_reg       <= '0;
            x_reg         <= DEF_X0;
            y_reg         <= DEF_Y0;
            pos_x_reg     <= '0;
            pos_y_reg     <= '0;
            frame_reg     <= '0;
        end else begin
            cfg_error_reg <= transfer && cfg_bad;
            div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            // transfer implies !pending_reg, so it never collides with the apply below
            if (transfer && !cfg_bad) begin
                for (int i = 0; i < 4; i++) begin
                    pend_h_reg[i] <= cfg_h[i];
                    pend_v_reg[i] <= cfg_v[i];
                end
                pend_hpol_reg <= cfg_hsync_pol;
                pend_vpol_reg <= cfg_vsync_pol;
                pending_reg   <= 1'b1;
            end
            if (pix_en) begin
                x_reg     <= x_next;
                y_reg     <= y_next;
                pos_x_reg <= position_x_next;
                pos_y_reg <= position_y_next;
            end
            if (frame_wrap) begin
                frame_reg <= frame_reg + 1'b1;
                if (pending_reg) begin
                    for (int i = 0; i < 4; i++) begin
                        act_h_reg[i] <= pend_h_reg[i];
                        act_v_reg[i] <= pend_v_reg[i];
                    end
                    act_hpol_reg <= pend_hpol_reg;
                    act_vpol_reg <= pend_vpol_reg;
                    pending_reg  <= 1'b0;
                end
            end
        end
    end

endmodule
